led_seq_ctrl: RTL and testbench

Sequencer for the LED board datapath: it decides which LED pattern is shown, in which colour, and at what rate. It programs the free-running tick counter (limit and enable) from the speed/enable switches and consumes the counter's one-cycle tick. On each accepted tick it steps a mode FSM (shift-left, shift-right, flash) and drives the blue and green LED banks. Colour changes only at pattern boundaries, never mid-sweep.

---
 rtl/led_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_led_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// LED board sequencer: programs the tick counter from the switches and steps a
// shift-left / shift-right / flash pattern FSM on each accepted counter tick.
module led_seq_ctrl #(
    parameter int                    NB_LEDS    = 4,
    parameter int                    NB_COUNTER = 16,
    parameter int                    NB_SW      = 4,
    parameter int                    N_PASSES   = 2,
    parameter logic [NB_COUNTER-1:0] LIM0       = 16'd60000,
    parameter logic [NB_COUNTER-1:0] LIM1       = 16'd30000,
    parameter logic [NB_COUNTER-1:0] LIM2       = 16'd15000,
    parameter logic [NB_COUNTER-1:0] LIM3       = 16'd7500
) (
    input  logic                  clock,
    input  logic                  i_reset,
    input  logic [NB_SW-1:0]      i_sw,
    input  logic                  i_tick,
    output logic [NB_COUNTER-1:0] o_count_limit,
    output logic                  o_count_enable,
    output logic [NB_LEDS-1:0]    o_led,
    output logic [NB_LEDS-1:0]    o_led_b,
    output logic [NB_LEDS-1:0]    o_led_g,
    output logic [1:0]            o_state
);
    localparam int S_W = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1;
    localparam int P_W = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;
    localparam logic [S_W-1:0] S_LAST = S_W'(NB_LEDS - 1);
    localparam logic [P_W-1:0] P_LAST = P_W'(N_PASSES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT_L = 2'd1, SHIFT_R = 2'd2, FLASH = 2'd3} state_t;

    state_t         state, state_nxt;
    logic [S_W-1:0] s, s_nxt;
    logic [P_W-1:0] p, p_nxt;
    logic           c, c_nxt;
    logic           accept;
    logic [NB_LEDS-1:0] led_nxt;

    function automatic logic [NB_LEDS-1:0] pattern(input state_t st, input logic [S_W-1:0] step);
        logic [NB_LEDS-1:0] one;
        one = NB_LEDS'(1);
        case (st)
            SHIFT_L: return one << step;
            SHIFT_R: return one << (S_LAST - step);
            FLASH:   return step[0] ? '0 : '1;
            default: return '0;
        endcase
    endfunction

    function automatic logic [NB_COUNTER-1:0] limit_of(input logic [1:0] code);
        case (code)
            2'd0:    return LIM0;
            2'd1:    return LIM1;
            2'd2:    return LIM2;
            default: return LIM3;
        endcase
    endfunction

    assign accept = i_tick && i_sw[0] && (state != IDLE);

    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        p_nxt     = p;
        c_nxt     = c;
        if (state == IDLE) begin
            if (i_sw[0]) begin
                state_nxt = SHIFT_L;
                s_nxt     = '0;
                p_nxt     = '0;
                c_nxt     = i_sw[3];
            end
        end else if (accept) begin
            if (s < S_LAST) begin
                s_nxt = s + S_W'(1);
            end else begin
                // Pass boundary: the only point where colour may change.
                s_nxt = '0;
                c_nxt = i_sw[3];
                if (p < P_LAST) begin
                    p_nxt = p + P_W'(1);
                end else begin
                    p_nxt = '0;
                    case (state)
                        SHIFT_L: state_nxt = SHIFT_R;
                        SHIFT_R: state_nxt = FLASH;
                        default: state_nxt = SHIFT_L;
                    endcase
                end
            end
        end
        led_nxt = pattern(state_nxt, s_nxt);
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state          <= IDLE;
            s              <= '0;
            p              <= '0;
            c              <= 1'b0;
            o_led          <= '0;
            o_led_b        <= '0;
            o_led_g        <= '0;
            o_count_enable <= 1'b0;
            o_count_limit  <= LIM0;
        end else begin
            state          <= state_nxt;
            s              <= s_nxt;
            p              <= p_nxt;
            c              <= c_nxt;
            o_led          <= led_nxt;
            o_led_b        <= c_nxt ? '0 : led_nxt;
            o_led_g        <= c_nxt ? led_nxt : '0;
            o_count_enable <= i_sw[0];
            o_count_limit  <= limit_of(i_sw[2:1]);
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: a behavioural model queues the expected
// outputs per driven cycle; each scenario drains and compares them.
module tb_led_seq_ctrl;
    logic        clock = 1'b0;
    logic        i_reset = 1'b1;
    logic [3:0]  i_sw = 4'b0000;
    logic        i_tick = 1'b0;
    logic [15:0] o_count_limit;
    logic        o_count_enable;
    logic [3:0]  o_led, o_led_b, o_led_g;
    logic [1:0]  o_state;

    led_seq_ctrl #(
        .NB_LEDS(4), .NB_COUNTER(16), .NB_SW(4), .N_PASSES(2),
        .LIM0(16'd7), .LIM1(16'd5), .LIM2(16'd3), .LIM3(16'd1)
    ) dut (
        .clock(clock), .i_reset(i_reset), .i_sw(i_sw), .i_tick(i_tick),
        .o_count_limit(o_count_limit), .o_count_enable(o_count_enable),
        .o_led(o_led), .o_led_b(o_led_b), .o_led_g(o_led_g), .o_state(o_state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]  st;
        logic [3:0]  led;
        logic [3:0]  b;
        logic [3:0]  g;
        logic [15:0] lim;
        logic        en;
    } obs_t;

    obs_t exp_q[$];
    obs_t got_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model state: mode 0 idle, 1 left, 2 right, 3 flash
    int   m_mode = 0, m_s = 0, m_p = 0;
    logic m_c = 1'b0;
    obs_t m_out = '0;

    function automatic obs_t sample();
        obs_t o;
        o.st = o_state; o.led = o_led; o.b = o_led_b; o.g = o_led_g;
        o.lim = o_count_limit; o.en = o_count_enable;
        return o;
    endfunction

    function automatic logic [3:0] model_led(input int mode, input int step);
        case (mode)
            1: return 4'b0001 << step;
            2: return 4'b1000 >> step;
            3: return (step % 2 == 0) ? 4'b1111 : 4'b0000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic cyc(input logic rst, input logic [3:0] sw, input logic tick);
        logic [15:0] lims [4];
        lims[0] = 16'd7; lims[1] = 16'd5; lims[2] = 16'd3; lims[3] = 16'd1;
        i_reset = rst; i_sw = sw; i_tick = tick;
        if (rst) begin
            m_mode = 0; m_s = 0; m_p = 0; m_c = 1'b0;
            m_out = '0;
            m_out.lim = 16'd7;
        end else begin
            if (m_mode == 0) begin
                if (sw[0]) begin
                    m_mode = 1; m_s = 0; m_p = 0; m_c = sw[3];
                end
            end else if (tick && sw[0]) begin
                m_s = m_s + 1;
                if (m_s == 4) begin
                    m_s = 0;
                    m_c = sw[3];
                    m_p = m_p + 1;
                    if (m_p == 2) begin
                        m_p = 0;
                        m_mode = (m_mode == 3) ? 1 : m_mode + 1;
                    end
                end
            end
            m_out.st  = 2'(m_mode);
            m_out.led = model_led(m_mode, m_s);
            m_out.b   = m_c ? 4'b0000 : m_out.led;
            m_out.g   = m_c ? m_out.led : 4'b0000;
            m_out.lim = lims[sw[2:1]];
            m_out.en  = sw[0];
        end
        exp_q.push_back(m_out);
        @(posedge clock);
        #1;
        got_q.push_back(sample());
    endtask

    task automatic test_reset();
        obs_t e, g;
        repeat (3) cyc(1'b1, 4'b1111, 1'b1);
        n_checks++;
        if (o_state !== 2'd0 || o_led !== 4'd0 || o_led_b !== 4'd0 || o_led_g !== 4'd0 ||
            o_count_enable !== 1'b0 || o_count_limit !== 16'd7)
            $display("FAIL reset_values: got st=%0d led=%b b=%b g=%b en=%b lim=%0d, expected 0/0000/0000/0000/0/7",
                     o_state, o_led, o_led_b, o_led_g, o_count_enable, o_count_limit);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) $display("FAIL reset_sb: got %h expected %h", g, e);
            else n_pass++;
        end
    endtask

    task automatic test_enable_shift();
        obs_t e, g;
        logic [3:0] want [4];
        want[0] = 4'b0010; want[1] = 4'b0100; want[2] = 4'b1000; want[3] = 4'b0001;
        cyc(1'b0, 4'b0001, 1'b0);
        n_checks++;
        if (o_state !== 2'd1 || o_led !== 4'b0001 || o_led_b !== 4'b0001 || o_led_g !== 4'b0000)
            $display("FAIL enable_entry: got st=%0d led=%b b=%b g=%b, expected 1/0001/0001/0000",
                     o_state, o_led, o_led_b, o_led_g);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 4'b0001, 1'b1);
            n_checks++;
            if (o_led !== want[i]) $display("FAIL shift_tick%0d: got led=%b expected %b", i + 1, o_led, want[i]);
            else n_pass++;
            cyc(1'b0, 4'b0001, 1'b0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) $display("FAIL shift_sb: got %h expected %h", g, e);
            else n_pass++;
        end
    endtask

    task automatic test_mode_walk();
        obs_t e, g;
        // Second pass of SHIFT_L, back-to-back ticks every cycle
        repeat (4) cyc(1'b0, 4'b0001, 1'b1);
        n_checks++;
        if (o_state !== 2'd2 || o_led !== 4'b1000)
            $display("FAIL walk_right: got st=%0d led=%b expected 2/1000", o_state, o_led);
        else n_pass++;
        repeat (8) cyc(1'b0, 4'b0001, 1'b1);
        n_checks++;
        if (o_state !== 2'd3 || o_led !== 4'b1111)
            $display("FAIL walk_flash: got st=%0d led=%b expected 3/1111", o_state, o_led);
        else n_pass++;
        cyc(1'b0, 4'b0001, 1'b1);
        n_checks++;
        if (o_led !== 4'b0000) $display("FAIL flash_alt: got led=%b expected 0000", o_led);
        else n_pass++;
        repeat (7) cyc(1'b0, 4'b0001, 1'b1);
        n_checks++;
        if (o_state !== 2'd1 || o_led !== 4'b0001)
            $display("FAIL walk_wrap: got st=%0d led=%b expected 1/0001", o_state, o_led);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) $display("FAIL walk_sb: got %h expected %h", g, e);
            else n_pass++;
        end
    endtask

    task automatic test_colour();
        obs_t e, g;
        cyc(1'b0, 4'b0001, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 4'b1001, 1'b1);
            n_checks++;
            if (o_led_g !== 4'b0000) $display("FAIL colour_defer%0d: got g=%b expected 0000", i, o_led_g);
            else n_pass++;
        end
        cyc(1'b0, 4'b1001, 1'b1);
        n_checks++;
        if (o_led_g !== 4'b0001 || o_led_b !== 4'b0000)
            $display("FAIL colour_switch: got g=%b b=%b expected 0001/0000", o_led_g, o_led_b);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) $display("FAIL colour_sb: got %h expected %h", g, e);
            else n_pass++;
        end
    endtask

    task automatic test_pause();
        obs_t e, g;
        logic [3:0] held;
        held = o_led;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 4'b1000, i[0] ? 1'b0 : 1'b1);
            n_checks++;
            if (o_led !== held || o_count_enable !== 1'b0)
                $display("FAIL pause_hold%0d: got led=%b en=%b expected %b/0", i, o_led, o_count_enable, held);
            else n_pass++;
        end
        cyc(1'b0, 4'b1001, 1'b1);
        n_checks++;
        if (o_led !== {held[2:0], held[3]})
            $display("FAIL pause_resume: got led=%b expected %b", o_led, {held[2:0], held[3]});
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) $display("FAIL pause_sb: got %h expected %h", g, e);
            else n_pass++;
        end
    endtask

    task automatic test_speed_reset();
        obs_t e, g;
        logic [3:0] held;
        held = o_led;
        cyc(1'b0, 4'b1101, 1'b0);
        n_checks++;
        if (o_count_limit !== 16'd3 || o_led !== held)
            $display("FAIL speed_change: got lim=%0d led=%b expected 3/%b", o_count_limit, o_led, held);
        else n_pass++;
        for (int i = 0; i < 64 && m_mode != 3; i++) cyc(1'b0, 4'b1111, 1'b1);
        n_checks++;
        if (o_state !== 2'd3) $display("FAIL reach_flash: got st=%0d expected 3", o_state);
        else n_pass++;
        cyc(1'b0, 4'b1101, 1'b1);
        cyc(1'b1, 4'b1101, 1'b1);
        n_checks++;
        if (o_state !== 2'd0 || o_led !== 4'd0 || o_led_b !== 4'd0 || o_led_g !== 4'd0 ||
            o_count_limit !== 16'd7 || o_count_enable !== 1'b0)
            $display("FAIL midrun_reset: got st=%0d led=%b b=%b g=%b lim=%0d en=%b expected 0/0000/0000/0000/7/0",
                     o_state, o_led, o_led_b, o_led_g, o_count_limit, o_count_enable);
        else n_pass++;
        cyc(1'b0, 4'b0000, 1'b1);
        cyc(1'b0, 4'b0000, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) $display("FAIL speed_reset_sb: got %h expected %h", g, e);
            else n_pass++;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_enable_shift();
        test_mode_walk();
        test_colour();
        test_pause();
        test_speed_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
